// File: rtl/up16_debug_monitor.sv
// rtl/up16_debug_monitor.sv - up16 bus debug monitor: halt detect, breakpoints, watchdog, trace
// Observes the cpu<->memory bus and requests a cpu stall on halt, breakpoint hit or watchdog expiry.
module up16_debug_monitor #(
   parameter int AW = 12,
   parameter int DW = 16,
   parameter int DEPTH = 16,
   parameter int NBP = 2,
   parameter int WDT_W = 16,
   parameter logic [DW-1:0] HLT_INSTR = 16'h7001
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       resume,
   input  logic                       bus_en,
   input  logic                       bus_rdwr,
   input  logic [AW-1:0]              bus_addr,
   input  logic [DW-1:0]              bus_wdata,
   input  logic [DW-1:0]              bus_rdata,
   input  logic                       exec_strobe,
   input  logic [DW-1:0]              ir,
   input  logic [DW-1:0]              acc,
   input  logic [NBP*AW-1:0]          bp_addr,
   input  logic [NBP-1:0]             bp_en,
   input  logic [$clog2(DEPTH)-1:0]   trc_idx,
   output logic [AW+DW:0]             trc_data,
   output logic [$clog2(DEPTH):0]     trc_count,
   output logic [2:0]                 state,
   output logic                       cpu_stall,
   output logic [2:0]                 bp_id,
   output logic [DW-1:0]              halt_acc,
   output logic [31:0]                instr_cnt
);

   localparam int IW = $clog2(DEPTH);
   localparam int TW = 1 + AW + DW;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      BRK     = 3'd2,
      HALTED  = 3'd3,
      TIMEOUT = 3'd4
   } st_t;

   st_t              state_q, state_d;
   logic [WDT_W-1:0] wd_q;
   logic             skip_q;
   logic [IW-1:0]    wr_ptr;
   logic [IW-1:0]    rd_ptr;
   logic [TW-1:0]    trc_mem [DEPTH];
   logic [TW-1:0]    wr_entry;

   logic       halt_hit, bp_hit, bp_take, wd_to, run_act, trc_wr;
   logic [2:0] bp_k;

   assign state    = state_q;
   assign run_act  = (state_q == RUN) && arm;
   assign halt_hit = exec_strobe && (ir == HLT_INSTR);
   assign bp_take  = bus_en && !bus_rdwr && bp_hit && !skip_q;
   assign wd_to    = (wd_q == '1) && !exec_strobe;
   assign trc_wr   = run_act && bus_en;
   assign wr_entry = {bus_rdwr, bus_addr, bus_rdwr ? bus_wdata : bus_rdata};

   // Descending scan so the lowest matching breakpoint index is the one kept.
   always_comb begin
      bp_hit = 1'b0;
      bp_k   = 3'd0;
      for (int k = NBP - 1; k >= 0; k--) begin
         if (bp_en[k] && (bp_addr[k*AW +: AW] == bus_addr)) begin
            bp_hit = 1'b1;
            bp_k   = 3'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (arm) state_d = RUN;
         RUN: begin
            if (halt_hit)     state_d = HALTED;
            else if (bp_take) state_d = BRK;
            else if (wd_to)   state_d = TIMEOUT;
         end
         BRK:     if (resume) state_d = RUN;
         default: state_d = state_q;
      endcase
      if (!arm) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_stall <= 1'b0;
         bp_id     <= 3'd0;
         halt_acc  <= '0;
         instr_cnt <= 32'd0;
         wd_q      <= '0;
         skip_q    <= 1'b0;
         wr_ptr    <= '0;
         trc_count <= '0;
      end else begin
         cpu_stall <= (state_q == BRK) || (state_q == HALTED) || (state_q == TIMEOUT);
         if ((state_q == IDLE) && arm) begin
            instr_cnt <= 32'd0;
            wd_q      <= '0;
            skip_q    <= 1'b0;
         end
         if (run_act) begin
            if (exec_strobe) begin
               instr_cnt <= instr_cnt + 32'd1;
               wd_q      <= '0;
            end else begin
               wd_q <= wd_q + 1'b1;
            end
            if (halt_hit)     halt_acc <= acc;
            else if (bp_take) bp_id    <= bp_k;
            if (bus_en) skip_q <= 1'b0;
         end
         // Skip lets the cpu step past the breakpoint it just stopped on.
         if ((state_q == BRK) && arm && resume) skip_q <= 1'b1;
         if (trc_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (trc_count != (IW+1)'(DEPTH)) trc_count <= trc_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (trc_wr) trc_mem[wr_ptr] <= wr_entry;
   end

   // Index 0 is the oldest valid entry; when full, the oldest sits at wr_ptr.
   assign rd_ptr   = wr_ptr - trc_count[IW-1:0] + trc_idx;
   assign trc_data = ({1'b0, trc_idx} < trc_count) ? trc_mem[rd_ptr] : '0;

endmodule
